sha256_msg_pad: RTL and testbench

SHA256_MSG_PAD -- requirements
Module: sha256_msg_pad

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/sha256_pad_fill.sv | 31 +++
 rtl/sha256_msg_pad.sv | 145 ++++++++++++++
 tb/tb_sha256_msg_pad.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Covers the FSM states, the kinds of trailing extra block, and the fill modes.
package sha256_pkg;

  localparam int S_DATA_W    = 256;
  localparam int M_DATA_W    = 512;
  localparam int S_KEEP_W    = S_DATA_W / 8;
  localparam int BLOCK_BYTES = 64;
  localparam int LEN_BYTES   = 8;
  localparam int CNT_W       = 61;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ACC_LO    = 2'd0,
    ACC_HI    = 2'd1,
    PAD_EXTRA = 2'd2
  } pad_state_t;

  typedef enum logic {
    LEN_ONLY = 1'b0,
    MARK_LEN = 1'b1
  } extra_kind_t;

  typedef enum logic [1:0] {
    FILL_DATA     = 2'd0,
    FILL_MARK     = 2'd1,
    FILL_MARK_LEN = 2'd2,
    FILL_LEN      = 2'd3
  } fill_mode_t;

  // Byte count of a last beat: the run of ones in tkeep starting at bit 31.
  function automatic logic [5:0] keep_bytes(input logic [S_KEEP_W-1:0] keep);
    logic       run;
    logic [5:0] n;
    run = 1'b1;
    n   = '0;
    for (int i = S_KEEP_W - 1; i >= 0; i--) begin
      run = run & keep[i];
      n   = n + {5'd0, run};
    end
    return n;
  endfunction

endpackage

// File: rtl/sha256_pad_fill.sv
// Builds one 512-bit block: the first b data bytes, an optional 0x80 marker at
// byte b, zero fill, and an optional 64-bit big-endian length in bytes 56-63.
module sha256_pad_fill
  import sha256_pkg::*;
(
  input  logic [M_DATA_W-1:0] data,
  input  logic [6:0]          b,
  input  logic [63:0]         len,
  input  fill_mode_t          mode,
  output logic [M_DATA_W-1:0] block
);

  logic mark;
  logic len_en;

  assign mark   = (mode == FILL_MARK) || (mode == FILL_MARK_LEN);
  assign len_en = (mode == FILL_MARK_LEN) || (mode == FILL_LEN);

  always_comb begin
    block = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (i < int'(b))
        block[M_DATA_W-1-8*i -: 8] = data[M_DATA_W-1-8*i -: 8];
      else if ((i == int'(b)) && mark)
        block[M_DATA_W-1-8*i -: 8] = PAD_BYTE;
      if (len_en && (i >= BLOCK_BYTES - LEN_BYTES))
        block[M_DATA_W-1-8*i -: 8] = len[8*(BLOCK_BYTES-1-i) +: 8];
    end
  end

endmodule

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: packs 256-bit message beats into padded 512-bit
// blocks with the 0x80 marker and the 64-bit bit-length trailer.
module sha256_msg_pad
  import sha256_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = S_DATA_W,
  parameter int M_AXIS_TDATA_WIDTH = M_DATA_W
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  pad_state_t    state, state_next;
  extra_kind_t   kind, kind_next;
  logic [CNT_W-1:0]    cnt, cnt_sum;
  logic [S_DATA_W-1:0] lo;

  logic          out_free, accept;
  logic [5:0]    beat_n;
  logic [M_DATA_W-1:0] fill_data, fill_block;
  logic [6:0]    fill_b;
  logic [63:0]   fill_len;
  fill_mode_t    fill_mode;
  logic          load, load_last, store_lo;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = ((state == ACC_LO) || (state == ACC_HI)) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign m_axis_tkeep  = '1;

  // Only a last beat can be short; earlier beats always carry 32 bytes.
  assign beat_n   = s_axis_tlast ? keep_bytes(s_axis_tkeep) : 6'd32;
  assign cnt_sum  = cnt + CNT_W'(beat_n);
  assign fill_len = (state == PAD_EXTRA) ? {cnt, 3'b000} : {cnt_sum, 3'b000};

  sha256_pad_fill u_fill (
    .data  (fill_data),
    .b     (fill_b),
    .len   (fill_len),
    .mode  (fill_mode),
    .block (fill_block)
  );

  always_comb begin
    state_next = state;
    kind_next  = kind;
    fill_data  = '0;
    fill_b     = 7'd0;
    fill_mode  = FILL_DATA;
    load       = 1'b0;
    load_last  = 1'b0;
    store_lo   = 1'b0;
    case (state)
      ACC_LO: begin
        fill_data = {s_axis_tdata, {S_DATA_W{1'b0}}};
        fill_b    = {1'b0, beat_n};
        fill_mode = FILL_MARK_LEN;
        if (accept) begin
          if (!s_axis_tlast) begin
            store_lo   = 1'b1;
            state_next = ACC_HI;
          end else begin
            load      = 1'b1;
            load_last = 1'b1;
          end
        end
      end
      ACC_HI: begin
        fill_data = {lo, s_axis_tdata};
        fill_b    = 7'd32 + {1'b0, beat_n};
        if (!s_axis_tlast || (fill_b == 7'd64))
          fill_mode = FILL_DATA;
        else if (fill_b <= 7'd55)
          fill_mode = FILL_MARK_LEN;
        else
          fill_mode = FILL_MARK;
        if (accept) begin
          load       = 1'b1;
          state_next = ACC_LO;
          if (s_axis_tlast) begin
            if (fill_b <= 7'd55) begin
              load_last = 1'b1;
            end else begin
              // No room for the length: it goes in a trailing block.
              state_next = PAD_EXTRA;
              kind_next  = (fill_b == 7'd64) ? MARK_LEN : LEN_ONLY;
            end
          end
        end
      end
      PAD_EXTRA: begin
        fill_mode = (kind == MARK_LEN) ? FILL_MARK_LEN : FILL_LEN;
        if (out_free) begin
          load       = 1'b1;
          load_last  = 1'b1;
          state_next = ACC_LO;
        end
      end
      default: state_next = ACC_LO;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state <= ACC_LO;
      kind  <= LEN_ONLY;
      cnt   <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      kind  <= kind_next;
      if (store_lo)
        lo <= s_axis_tdata;
      if (load_last)
        cnt <= '0;
      else if (accept)
        cnt <= cnt_sum;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= load_last;
      m_axis_tdata  <= fill_block;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Testbench for sha256_msg_pad: directed and randomised messages checked
// against a standard SHA-256 padding model through an expected-block queue.
module tb_sha256_msg_pad;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last;
  logic [255:0] s_data;
  logic [31:0]  s_keep;
  logic         m_valid, m_ready, m_last;
  logic [511:0] m_data;
  logic [63:0]  m_keep;

  logic [512:0] exp_q[$];
  logic [512:0] mon_e;
  int  checks   = 0;
  int  failures = 0;
  bit  rand_bp  = 1'b0;

  sha256_msg_pad dut (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [512:0] obs, input logic [512:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: standard SHA-256 padding of a byte string into tagged blocks.
  function automatic void push_model(input logic [7:0] msg[$]);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nblk;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nblk = p.size() / 64;
    for (int bi = 0; bi < nblk; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
      exp_q.push_back({(bi == nblk - 1), blk});
    end
  endfunction

  // driver tasks
  task automatic wait_accept(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 500) begin
        checks++;
        failures++;
        $error("FAIL accept_timeout waited=%0d limit=500", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                           output int waited);
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    wait_accept(waited);
  endtask

  task automatic send_msg(input int len, input bit noise, input bit zero_tail, input bit no_idle);
    logic [7:0]   msg[$];
    logic [255:0] d;
    logic [31:0]  k;
    int           nb, r, w;
    bit           extra, is_last;
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
    push_model(msg);
    nb    = (len + 31) / 32;
    extra = (len == 0) || (zero_tail && (len % 32 == 0));
    for (int i = 0; i < nb; i++) begin
      r       = (len - 32*i >= 32) ? 32 : len - 32*i;
      is_last = (i == nb - 1) && !extra;
      for (int j = 0; j < 32; j++)
        d[255-8*j -: 8] = (32*i + j < len) ? msg[32*i+j] : (noise ? 8'($urandom_range(0, 255)) : 8'h00);
      if (!is_last) begin
        k = noise ? 32'($urandom()) : 32'hFFFF_FFFF;
      end else begin
        k = ~(32'hFFFF_FFFF >> r);
        if (noise && r < 31) k = k | (32'($urandom()) & ((32'h1 << (31 - r)) - 32'h1));
      end
      send_beat(d, k, is_last, w);
      if (no_idle) chk("no_idle_wait", 513'(w), 513'd0);
    end
    if (extra) begin
      d = noise ? {8{32'($urandom())}} : '0;
      k = noise ? (32'($urandom()) & 32'h7FFF_FFFF) : 32'h0;
      send_beat(d, k, 1'b1, w);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 513'(exp_q.size()), 513'd0);
  endtask

  function automatic logic [512:0] abc_block();
    logic [511:0] blk;
    blk          = '0;
    blk[511:480] = 32'h6162_6380;
    blk[63:0]    = 64'h18;
    return {1'b1, blk};
  endfunction

  // scoreboard: compare each block as it transfers
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      chk("tkeep_ones", 513'(m_keep), 513'({64{1'b1}}));
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_block observed=%h expected=none", {m_last, m_data});
      end else begin
        mon_e = exp_q.pop_front();
        chk("block", {m_last, m_data}, mon_e);
      end
    end
  end

  // random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int          w;
    int          lens[7];
    logic [7:0]  m3[$];
    logic [255:0] d;

    lens = '{55, 56, 63, 96, 119, 120, 128};
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", 513'(m_valid), 513'd0);
    chk("reset_tlast", 513'(m_last), 513'd0);
    chk("reset_tdata", 513'(m_data), 513'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tready", 513'(s_ready), 513'd1);
    @(posedge clk);
    #1;

    // "abc" with fixed expectation and one-cycle latency
    exp_q.push_back(abc_block());
    send_beat({24'h616263, 232'd0}, 32'hE000_0000, 1'b1, w);
    @(negedge clk);
    chk("abc_latency_tvalid", 513'(m_valid), 513'd1);
    wait_drain();
    @(posedge clk); #1;

    send_msg(56, 1'b0, 1'b0, 1'b0);
    send_msg(64, 1'b0, 1'b0, 1'b0);
    send_msg(64, 1'b0, 1'b1, 1'b0);
    send_msg(0, 1'b0, 1'b0, 1'b0);
    send_msg(32, 1'b0, 1'b0, 1'b1);
    send_msg(32, 1'b0, 1'b0, 1'b1);
    wait_drain();
    @(posedge clk); #1;

    // stall: block held while a new beat waits
    m_ready = 1'b0;
    send_msg(32, 1'b0, 1'b0, 1'b0);
    m3 = {8'h11, 8'h22, 8'h33};
    push_model(m3);
    s_data = {24'h112233, 232'd0}; s_keep = 32'hE000_0000; s_last = 1'b1; s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_s_tready", 513'(s_ready), 513'd0);
      chk("stall_tvalid", 513'(m_valid), 513'd1);
      chk("stall_block", {m_last, m_data}, exp_q[0]);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_accept(w);
    wait_drain();
    @(posedge clk); #1;

    // reset after one accepted beat
    send_beat({8{32'hDEAD_BEEF}}, 32'hFFFF_FFFF, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_tvalid", 513'(m_valid), 513'd0);
    @(posedge clk); #1 rst = 1'b0;
    // reset with a block pending on the output
    m_ready = 1'b0;
    d = {8{32'hCAFE_F00D}};
    send_beat(d, 32'hFFFF_0000, 1'b1, w);
    @(negedge clk);
    chk("pending_tvalid", 513'(m_valid), 513'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("pending_reset_tvalid", 513'(m_valid), 513'd0);
    @(posedge clk); #1 rst = 1'b0; m_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", 513'(m_valid), 513'd0);
    end
    @(posedge clk); #1;
    exp_q.push_back(abc_block());
    send_beat({24'h616263, 232'd0}, 32'hE000_0000, 1'b1, w);
    wait_drain();
    @(posedge clk); #1;

    // boundary and random lengths with noisy tkeep/data and backpressure
    rand_bp = 1'b1;
    foreach (lens[i]) send_msg(lens[i], 1'b1, 1'b0, 1'b0);
    repeat (12) send_msg($urandom_range(0, 150), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk);
    rand_bp = 1'b0;
    #2 m_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
